frac_mult_seq: RTL and testbench

FRAC_MULT_SEQ -- requirements
Module: frac_mult_seq

---
 rtl/frac_mult_seq.sv | 186 ++++++++++++++++++
 tb/tb_frac_mult_seq.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/frac_mult_seq.sv
// ---------------------------------------------------------------------------
// frac_mult_seq
//   Sequential signed fractional multiplier using add-shift (Booth-free,
//   sign-corrected). Operands are two's-complement Q0.(N-1) fractions. One
//   add-shift step runs per clock in ITER. The last step subtracts the
//   multiplicand because it handles the multiplier's sign bit. The result is
//   loaded into registered outputs when the operation completes.
//
// Parameters
//   N    operand width in bits (2..32)
//   SAT  1: saturate the -1 x -1 product to max positive, 0: wrap
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset
//   st_i         start request, sampled only in IDLE
//   mplier_i     multiplier, Q0.(N-1)
//   mcand_i      multiplicand, Q0.(N-1)
//   product_o    full product, Q0.(2N-2), registered
//   product_r_o  product rounded half-up to Q0.(N-1), registered
//   ovf_o        last result was -1 x -1
//   busy_o       high while iterating
//   done_o       one-cycle completion pulse
// ---------------------------------------------------------------------------
module frac_mult_seq #(
  parameter int N   = 8,
  parameter bit SAT = 1'b1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           st_i,
  input  logic [N-1:0]   mplier_i,
  input  logic [N-1:0]   mcand_i,
  output logic [2*N-2:0] product_o,
  output logic [N-1:0]   product_r_o,
  output logic           ovf_o,
  output logic           busy_o,
  output logic           done_o
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0]  LAST_CNT = CW'(N - 1);
  localparam logic [N-1:0]   MIN_N    = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0]   MAXPOS_N = {1'b0, {(N-1){1'b1}}};
  localparam logic [2*N-2:0] SAT_VAL  = SAT ? {1'b0, {(2*N-2){1'b1}}}
                                            : {1'b1, {(2*N-2){1'b0}}};

  // Round half up. Clamp when the increment would carry into the sign bit.
  function automatic logic [N-1:0] round_half_up(input logic [2*N-2:0] p);
    logic [N-1:0] hi;
    hi = p[2*N-2:N-1];
    if (p[N-2] && (hi == MAXPOS_N)) begin
      round_half_up = hi;
    end else begin
      round_half_up = hi + {{(N-1){1'b0}}, p[N-2]};
    end
  endfunction

  logic [1:0]     state_q,  state_d;
  logic [CW-1:0]  cnt_q,    cnt_d;
  logic [N:0]     acc_q,    acc_d;
  logic [N-1:0]   mpl_q,    mpl_d;
  logic [N-1:0]   mcand_q,  mcand_d;
  logic           minmin_q, minmin_d;
  logic [2*N-2:0] product_q, product_d;
  logic [N-1:0]   prodr_q,  prodr_d;
  logic           ovf_q,    ovf_d;
  logic           busy_q,   busy_d;
  logic           done_q,   done_d;

  logic [N:0]     mcand_ext_s;
  logic [N:0]     addend_s;
  logic [N:0]     sum_s;
  logic           last_s;
  logic [2*N-2:0] final_s;

  // Datapath for one add-shift step and for the final result.
  always_comb begin
    last_s      = (cnt_q == LAST_CNT);
    mcand_ext_s = {mcand_q[N-1], mcand_q};
    // The sign-bit step subtracts. The N+1-bit accumulator keeps the
    // result exact, including -(-1).
    if (mpl_q[0]) begin
      addend_s = last_s ? (-mcand_ext_s) : mcand_ext_s;
    end else begin
      addend_s = {(N+1){1'b0}};
    end
    sum_s   = acc_q + addend_s;
    // Once all steps are done, {acc, mpl} holds the sign-extended product.
    // Only its low 2N-1 bits are kept.
    final_s = minmin_q ? SAT_VAL : {acc_q[N-2:0], mpl_q};
  end

  // Next-state logic for the FSM and its registers.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mpl_d     = mpl_q;
    mcand_d   = mcand_q;
    minmin_d  = minmin_q;
    product_d = product_q;
    prodr_d   = prodr_q;
    ovf_d     = ovf_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (st_i) begin
          mpl_d    = mplier_i;
          mcand_d  = mcand_i;
          minmin_d = (mplier_i == MIN_N) && (mcand_i == MIN_N);
          acc_d    = {(N+1){1'b0}};
          cnt_d    = {CW{1'b0}};
          busy_d   = 1'b1;
          state_d  = S_ITER;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_ITER: begin
        // Arithmetic shift of {sum, mpl}. The sign comes from the true sum.
        acc_d = {sum_s[N], sum_s[N:1]};
        mpl_d = {sum_s[0], mpl_q[N-1:1]};
        if (last_s) begin
          busy_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        product_d = final_s;
        prodr_d   = round_half_up(final_s);
        ovf_d     = minmin_q;
        done_d    = 1'b1;
        state_d   = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= {CW{1'b0}};
      acc_q     <= {(N+1){1'b0}};
      mpl_q     <= {N{1'b0}};
      mcand_q   <= {N{1'b0}};
      minmin_q  <= 1'b0;
      product_q <= {(2*N-1){1'b0}};
      prodr_q   <= {N{1'b0}};
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mpl_q     <= mpl_d;
      mcand_q   <= mcand_d;
      minmin_q  <= minmin_d;
      product_q <= product_d;
      prodr_q   <= prodr_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign product_o   = product_q;
  assign product_r_o = prodr_q;
  assign ovf_o       = ovf_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_frac_mult_seq.sv
// ---------------------------------------------------------------------------
// tb_frac_mult_seq
//   Directed and table-driven bench for frac_mult_seq. It uses three
//   instances:
//     u4  N=4, SAT=1
//     u4w N=4, SAT=0
//     u8  N=8, SAT=1
//   u4 and u4w share the same stimulus.
// ---------------------------------------------------------------------------
module tb_frac_mult_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       st4, st8;
  logic [3:0] mpl4, mc4;
  logic [7:0] mpl8, mc8;

  logic [6:0]  prod4, prod4w;
  logic [3:0]  prodr4, prodr4w;
  logic        ovf4, ovf4w, busy4, busy4w, done4, done4w;
  logic [14:0] prod8;
  logic [7:0]  prodr8;
  logic        ovf8, busy8, done8;

  int tests = 0;
  int fails = 0;

  frac_mult_seq #(.N(4), .SAT(1'b1)) u4 (
    .clk_i(clk), .rst_i(rst), .st_i(st4), .mplier_i(mpl4), .mcand_i(mc4),
    .product_o(prod4), .product_r_o(prodr4), .ovf_o(ovf4),
    .busy_o(busy4), .done_o(done4));

  frac_mult_seq #(.N(4), .SAT(1'b0)) u4w (
    .clk_i(clk), .rst_i(rst), .st_i(st4), .mplier_i(mpl4), .mcand_i(mc4),
    .product_o(prod4w), .product_r_o(prodr4w), .ovf_o(ovf4w),
    .busy_o(busy4w), .done_o(done4w));

  frac_mult_seq #(.N(8), .SAT(1'b1)) u8 (
    .clk_i(clk), .rst_i(rst), .st_i(st8), .mplier_i(mpl8), .mcand_i(mc8),
    .product_o(prod8), .product_r_o(prodr8), .ovf_o(ovf8),
    .busy_o(busy8), .done_o(done8));

  // Sign-extend an n-bit value held in a longint.
  function automatic longint sx(input int n, input longint v);
    longint one;
    one = 64'sd1;
    return (v >= (one << (n - 1))) ? v - (one << n) : v;
  endfunction

  // Reference product: exact multiply, keep bits [2n-2:0], -1 x -1 special case.
  function automatic longint ref_prod(input int n, input longint a, input longint b, input bit sat);
    longint as_v, bs_v, mask, one;
    one  = 64'sd1;
    as_v = sx(n, a);
    bs_v = sx(n, b);
    mask = (one << (2 * n - 1)) - one;
    if ((as_v == -(one << (n - 1))) && (bs_v == as_v))
      return sat ? (mask >> 1) : (one << (2 * n - 2));
    return (as_v * bs_v) & mask;
  endfunction

  // Reference rounding: half up, clamp on carry into the sign bit.
  function automatic longint ref_round(input int n, input longint p);
    longint hi, r, one;
    one = 64'sd1;
    hi  = (p >> (n - 1)) & ((one << n) - one);
    r   = (p >> (n - 2)) & one;
    if ((r == one) && (hi == ((one << (n - 1)) - one)))
      return hi;
    return (hi + r) & ((one << n) - one);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start one N=4 operation and wait for Done. If chg is set, the inputs
  // change right after the start edge.
  task automatic run4(input logic [3:0] a, input logic [3:0] b, input bit chg);
    int cyc;
    mpl4 = a; mc4 = b; st4 = 1'b1;
    @(posedge clk); #1;
    st4 = 1'b0;
    chk("busy4_start", busy4, 64'd1);
    if (chg) begin mc4 = 4'b0001; mpl4 = 4'b1111; end
    cyc = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done4) begin cyc = i; break; end
    end
    chk("lat4", cyc, 64'd5);
    chk("done4w", done4w, 64'd1);
    chk("busy4_done", busy4, 64'd0);
    chk("prod4", prod4, ref_prod(4, a, b, 1'b1));
    chk("prodr4", prodr4, ref_round(4, ref_prod(4, a, b, 1'b1)));
    chk("ovf4", ovf4, ((a == 4'b1000) && (b == 4'b1000)) ? 64'd1 : 64'd0);
    chk("prod4w", prod4w, ref_prod(4, a, b, 1'b0));
    chk("prodr4w", prodr4w, ref_round(4, ref_prod(4, a, b, 1'b0)));
    @(posedge clk); #1;
    chk("done4_pulse", done4, 64'd0);
  endtask

  // Start one N=8 operation and wait for Done.
  task automatic run8(input logic [7:0] a, input logic [7:0] b);
    int cyc;
    mpl8 = a; mc8 = b; st8 = 1'b1;
    @(posedge clk); #1;
    st8 = 1'b0;
    cyc = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (done8) begin cyc = i; break; end
    end
    chk("lat8", cyc, 64'd9);
    chk("prod8", prod8, ref_prod(8, a, b, 1'b1));
    chk("prodr8", prodr8, ref_round(8, ref_prod(8, a, b, 1'b1)));
    chk("ovf8", ovf8, ((a == 8'h80) && (b == 8'h80)) ? 64'd1 : 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int gap;
    int ndone;
    rst = 1'b1; st4 = 1'b0; st8 = 1'b0;
    mpl4 = 4'b0000; mc4 = 4'b0000; mpl8 = 8'h00; mc8 = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_prod4", prod4, 64'd0);
    chk("rst_prodr4", prodr4, 64'd0);
    chk("rst_ovf4", ovf4, 64'd0);
    chk("rst_busy4", busy4, 64'd0);
    chk("rst_done4", done4, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 0.5 x 0.5 = 0.25
    run4(4'b0100, 4'b0100, 1'b0);
    chk("d34_prod", prod4, 64'b0010000);
    chk("d34_prodr", prodr4, 64'b0010);
    chk("d34_ovf", ovf4, 64'd0);

    // -0.5 x 0.75, with and without input changes during ITER
    run4(4'b1100, 4'b0110, 1'b0);
    chk("d35_prod", prod4, 64'b1101000);
    chk("d35_prodr", prodr4, 64'b1101);
    run4(4'b1100, 4'b0110, 1'b1);
    chk("d35_chg_prod", prod4, 64'b1101000);
    chk("d35_chg_prodr", prodr4, 64'b1101);

    // -1 x -1: saturate vs wrap
    run4(4'b1000, 4'b1000, 1'b0);
    chk("d36_ovf", ovf4, 64'd1);
    chk("d36_prod", prod4, 64'b0111111);
    chk("d36_prodr", prodr4, 64'b0111);
    chk("d36w_prod", prod4w, 64'b1000000);
    chk("d36w_ovf", ovf4w, 64'd1);

    // 0.875 x 0.875, then check that the outputs hold
    run4(4'b0111, 4'b0111, 1'b0);
    chk("d37_prod", prod4, 64'b0110001);
    chk("d37_prodr", prodr4, 64'b0110);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_prod", prod4, 64'b0110001);

    // St held high: back-to-back operations
    mpl4 = 4'b0111; mc4 = 4'b0111; st4 = 1'b1;
    gap = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done4) begin gap = i; break; end
    end
    chk("b2b_first", gap, 64'd6);
    @(posedge clk); #1;
    chk("b2b_busy_after_idle", busy4, 64'd1);
    gap = 1;
    for (int i = 2; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done4) begin gap = i; break; end
    end
    chk("b2b_gap", gap, 64'd6);
    chk("b2b_prod", prod4, 64'b0110001);
    st4 = 1'b0;
    repeat (8) @(posedge clk);
    #1;

    // Reset during the 2nd ITER cycle
    mpl4 = 4'b0101; mc4 = 4'b0011; st4 = 1'b1;
    @(posedge clk); #1;
    st4 = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy_pre", busy4, 64'd1);
    rst = 1'b1;
    #1;
    chk("abort_busy", busy4, 64'd0);
    chk("abort_prod", prod4, 64'd0);
    chk("abort_prodr", prodr4, 64'd0);
    chk("abort_ovf", ovf4, 64'd0);
    chk("abort_done", done4, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done4) ndone++;
    end
    chk("abort_no_done", ndone, 64'd0);
    run4(4'b0101, 4'b0011, 1'b0);
    chk("after_abort_prod", prod4, 64'b0001111);
    chk("after_abort_prodr", prodr4, 64'b0010);

    // All 256 operand pairs at N=4
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run4(4'(a), 4'(b), 1'b0);
      end
    end

    // N=8: corner cases, then random pairs
    run8(8'h80, 8'h80);
    chk("d8_minmin", prod8, 64'h3FFF);
    run8(8'h7F, 8'h7F);
    run8(8'h80, 8'h7F);
    run8(8'h00, 8'h80);
    for (int i = 0; i < 60; i++) begin
      run8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
